// File: rtl/road_scroller.sv
// Per-frame road scroll engine: integrates a ramped player speed into a
// sub-pixel scroll position that wraps on the median-dash period.
module road_scroller #(
  parameter int PERIOD    = 128,
  parameter int MAX_SPEED = 128,
  parameter int ACCEL     = 4,
  parameter int BRAKE_DEC = 12,
  parameter int DRAG      = 1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        new_frame_in,
  input  logic        throttle_in,
  input  logic        brake_in,
  input  logic        pause_in,
  output logic [12:0] x_out,
  output logic [7:0]  speed_out,
  output logic        moving_out
);

  localparam int PW = $clog2(PERIOD) + 4;
  localparam logic [PW:0] WRAP       = (PW + 1)'(PERIOD * 16);
  localparam logic [8:0]  MAX_SPEED9 = 9'(MAX_SPEED);
  localparam logic [8:0]  ACCEL9     = 9'(ACCEL);
  localparam logic [8:0]  BRAKE9     = 9'(BRAKE_DEC);
  localparam logic [8:0]  DRAG9      = 9'(DRAG);

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [7:0]      speed_q, speed_d;
  logic [PW:0]     pos_sum;
  logic [8:0]      speed_wide, speed_up, speed_next;

  // Nothing is updated outside a frame tick, so outputs never change mid-frame.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= STOPPED;
      pos_q   <= '0;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      speed_q <= speed_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    speed_d    = speed_q;
    pos_sum    = {1'b0, pos_q} + (PW + 1)'(speed_q);
    speed_wide = {1'b0, speed_q};
    speed_up   = speed_wide + ACCEL9;
    speed_next = speed_wide;

    if (new_frame_in && !pause_in) begin
      // MAX_SPEED < PERIOD*16, so a single conditional subtract wraps fully.
      if (pos_sum >= WRAP) begin
        pos_d = PW'(pos_sum - WRAP);
      end else begin
        pos_d = pos_sum[PW-1:0];
      end

      if (brake_in) begin
        speed_next = (speed_wide < BRAKE9) ? 9'd0 : speed_wide - BRAKE9;
      end else if (throttle_in) begin
        speed_next = (speed_up > MAX_SPEED9) ? MAX_SPEED9 : speed_up;
      end else begin
        speed_next = (speed_wide < DRAG9) ? 9'd0 : speed_wide - DRAG9;
      end
      speed_d = speed_next[7:0];

      case (state_q)
        STOPPED: if (speed_next != 9'd0) state_d = MOVING;
        MOVING:  if (speed_next == 9'd0) state_d = STOPPED;
        default: state_d = STOPPED;
      endcase
    end
  end

  assign x_out      = 13'(pos_q[PW-1:4]);
  assign speed_out  = speed_q;
  assign moving_out = (state_q == MOVING);

endmodule

// File: tb/tb_road_scroller.sv
// Directed scoreboard bench for road_scroller: a behavioural model pushes the
// expected outputs per step, and each step pops and checks them.
module tb_road_scroller;

  logic        clk_in;
  logic        rst_n_in;
  logic        new_frame_in;
  logic        throttle_in;
  logic        brake_in;
  logic        pause_in;
  logic [12:0] x_out;
  logic [7:0]  speed_out;
  logic        moving_out;

  typedef struct {
    logic [12:0] x;
    logic [7:0]  speed;
    logic        moving;
  } exp_t;

  exp_t sb_q[$];

  int checks;
  int failures;
  int m_pos;
  int m_speed;
  int m_moving;

  road_scroller dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .new_frame_in(new_frame_in),
    .throttle_in (throttle_in),
    .brake_in    (brake_in),
    .pause_in    (pause_in),
    .x_out       (x_out),
    .speed_out   (speed_out),
    .moving_out  (moving_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic pushModel();
    exp_t e;
    e.x      = 13'(m_pos / 16);
    e.speed  = 8'(m_speed);
    e.moving = (m_moving != 0);
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb_q.pop_front();
    assert (x_out === e.x) else begin
      failures++;
      $error("[TB] FAIL %s x_out got=%0d expected=%0d", tag, x_out, e.x);
    end
    checks++;
    assert (speed_out === e.speed) else begin
      failures++;
      $error("[TB] FAIL %s speed_out got=%0d expected=%0d", tag, speed_out, e.speed);
    end
    checks++;
    assert (moving_out === e.moving) else begin
      failures++;
      $error("[TB] FAIL %s moving_out got=%0b expected=%0b", tag, moving_out, e.moving);
    end
    checks++;
    assert (x_out < 13'd128) else begin
      failures++;
      $error("[TB] FAIL %s x_out_range got=%0d expected=<128", tag, x_out);
    end
  endtask

  // One frame tick; back-to-back calls give ticks on consecutive cycles.
  task automatic applyStimulus(input logic thr, input logic brk, input logic pau,
                               input string tag);
    @(negedge clk_in);
    throttle_in  = thr;
    brake_in     = brk;
    pause_in     = pau;
    new_frame_in = 1'b1;
    if (rst_n_in && !pau) begin
      m_pos = (m_pos + m_speed) % 2048;
      if (brk)      m_speed = (m_speed >= 12) ? m_speed - 12 : 0;
      else if (thr) m_speed = (m_speed + 4 > 128) ? 128 : m_speed + 4;
      else          m_speed = (m_speed >= 1) ? m_speed - 1 : 0;
      m_moving = (m_speed != 0) ? 1 : 0;
    end
    pushModel();
    @(posedge clk_in);
    #1;
    checkOutput(tag);
  endtask

  // Cycles without a tick while inputs churn: nothing may move.
  task automatic idleCycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      new_frame_in = 1'b0;
      throttle_in  = ~throttle_in;
      brake_in     = (i % 2) == 0;
      pause_in     = 1'b0;
    end
    pushModel();
    @(posedge clk_in);
    #1;
    checkOutput(tag);
  endtask

  task automatic modelReset();
    m_pos    = 0;
    m_speed  = 0;
    m_moving = 0;
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst_n_in     = 1'b0;
    new_frame_in = 1'b0;
    throttle_in  = 1'b0;
    brake_in     = 1'b0;
    pause_in     = 1'b0;
    modelReset();

    // Ticks during reset must have no effect
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, "reset_hold");
    @(negedge clk_in);
    new_frame_in = 1'b0;
    rst_n_in     = 1'b1;

    // Ramp: speed 4,8,12 with x 0; fourth tick puts pos at 24
    applyStimulus(1'b1, 1'b0, 1'b0, "ramp1");
    applyStimulus(1'b1, 1'b0, 1'b0, "ramp2");
    applyStimulus(1'b1, 1'b0, 1'b0, "ramp3");
    applyStimulus(1'b1, 1'b0, 1'b0, "ramp4");
    idleCycles(4, "between_ticks");

    // Ceiling, then wrap at full speed
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 1'b0, "ceiling");
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, "wrap");

    // Coast with drag
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, "drag");

    // Brake priority and floor from speed 20
    @(negedge clk_in);
    new_frame_in = 1'b0;
    rst_n_in     = 1'b0;
    modelReset();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0, 1'b0, "to_20");
    applyStimulus(1'b1, 1'b1, 1'b0, "brake_8");
    applyStimulus(1'b1, 1'b1, 1'b0, "brake_0");
    applyStimulus(1'b0, 1'b1, 1'b0, "brake_hold0");
    applyStimulus(1'b0, 1'b0, 1'b0, "drag_floor");

    // Pause freezes everything
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, "pre_pause");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, "pause");
    applyStimulus(1'b1, 1'b0, 1'b0, "post_pause");

    // Asynchronous reset mid-frame, checked before any clock edge
    @(posedge clk_in);
    #2;
    new_frame_in = 1'b0;
    rst_n_in     = 1'b0;
    modelReset();
    pushModel();
    #1;
    checkOutput("async_reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, "post_reset1");
    applyStimulus(1'b1, 1'b0, 1'b0, "post_reset2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
